// File: rtl/conv_window_mac_if.sv
// conv_window_mac_if: pixel, coefficient and result signals
// of the convolution window multiply-accumulate block.
interface conv_window_mac_if #(
   parameter int IMG_W = 28,
   parameter int K     = 5
);
   localparam int RW = $clog2(IMG_W - K + 1);

   logic             pix_valid;
   logic [K*K*8-1:0] window_in;
   logic             cfg_load;
   logic [K*K*8-1:0] weight_in;
   logic [15:0]      bias_in;
   logic             out_valid;
   logic [23:0]      out_data;
   logic [RW-1:0]    out_row;
   logic [RW-1:0]    out_col;
   logic             frame_done;
   logic             err;

   modport master (
      output pix_valid, window_in, cfg_load,
      output weight_in, bias_in,
      input  out_valid, out_data, out_row,
      input  out_col, frame_done, err
   );

   modport slave (
      input  pix_valid, window_in, cfg_load,
      input  weight_in, bias_in,
      output out_valid, out_data, out_row,
      output out_col, frame_done, err
   );
endinterface

// File: rtl/conv_window_mac.sv
// conv_window_mac: KxK window convolution over a streamed
// IMG_W x IMG_W frame, 3-stage MAC pipeline with optional ReLU.
module conv_window_mac #(
   parameter int IMG_W   = 28,
   parameter int K       = 5,
   parameter int RELU_EN = 1
) (
   input logic              clk,
   input logic              rst_n,
   conv_window_mac_if.slave bus
);
   localparam int N  = K * K;
   localparam int OW = IMG_W - K + 1;
   localparam int CW = $clog2(IMG_W);
   localparam int RW = $clog2(OW);
   localparam int PW = 16;
   localparam int SW = PW + $clog2(K);
   localparam int DW = 24;

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t               state, nxt;
   logic [CW-1:0]        row, col;
   logic [1:0]           dcnt;
   logic                 accept, drop, win, last;
   logic                 v0, v1, v2;
   logic [RW-1:0]        r0, c0, r1, c1, r2, c2;
   logic [N*8-1:0]       wgt;
   logic signed [15:0]   bias;
   logic signed [PW-1:0] prod [N];
   logic signed [SW-1:0] rsum [K];
   logic signed [SW-1:0] rsum_c [K];
   logic signed [DW-1:0] tot_c, res_c;

   // Unsigned pixel times signed weight; result always fits PW bits.
   function automatic logic signed [PW-1:0] mul(
      input logic [7:0] p,
      input logic [7:0] w
   );
      logic signed [PW:0] a, b, m;
      a = {{(PW-7){1'b0}}, p};
      b = {{(PW-7){w[7]}}, w};
      m = a * b;
      return m[PW-1:0];
   endfunction

   // State register.
   always_ff @(posedge clk) begin
      if (!rst_n) state <= IDLE;
      else        state <= nxt;
   end

   // Next state: a gap in the stream aborts the frame.
   always_comb begin
      nxt = state;
      unique case (state)
         IDLE:    if (bus.pix_valid) nxt = RUN;
         RUN: begin
            if (!bus.pix_valid) nxt = IDLE;
            else if (last)      nxt = DRAIN;
         end
         DRAIN:   if (dcnt == 2'd3) nxt = IDLE;
         default: nxt = IDLE;
      endcase
   end

   // FSM outputs: pixel acceptance, abort and window-complete.
   always_comb begin
      accept = bus.pix_valid && (state == IDLE || state == RUN);
      drop   = (state == RUN) && !bus.pix_valid;
      last   = (row == CW'(IMG_W-1)) && (col == CW'(IMG_W-1));
      win    = accept && (row >= CW'(K-1)) && (col >= CW'(K-1));
   end

   // Position counters, error flag, coefficients, valids, outputs.
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         row            <= '0;
         col            <= '0;
         dcnt           <= '0;
         bus.err        <= 1'b0;
         wgt            <= '0;
         bias           <= '0;
         v0             <= 1'b0;
         v1             <= 1'b0;
         v2             <= 1'b0;
         bus.out_valid  <= 1'b0;
         bus.frame_done <= 1'b0;
         bus.out_data   <= '0;
         bus.out_row    <= '0;
         bus.out_col    <= '0;
      end else begin
         dcnt <= (state == DRAIN) ? dcnt + 2'd1 : 2'd0;
         if (drop) begin
            row <= '0;
            col <= '0;
         end else if (accept) begin
            if (col == CW'(IMG_W-1)) begin
               col <= '0;
               row <= last ? '0 : row + 1'b1;
            end else begin
               col <= col + 1'b1;
            end
         end
         if (drop || (state == DRAIN && bus.pix_valid))
            bus.err <= 1'b1;
         else if (state == IDLE && bus.cfg_load)
            bus.err <= 1'b0;
         if (state == IDLE && bus.cfg_load) begin
            wgt  <= bus.weight_in;
            bias <= bus.bias_in;
         end
         v0             <= win;
         v1             <= v0 && !drop;
         v2             <= v1 && !drop;
         bus.out_valid  <= v2 && !drop;
         bus.frame_done <= v2 && !drop &&
                           r2 == RW'(OW-1) && c2 == RW'(OW-1);
         if (v2 && !drop) begin
            bus.out_data <= res_c;
            bus.out_row  <= r2;
            bus.out_col  <= c2;
         end
      end
   end

   // MAC datapath: products, then row sums, tagged with position.
   always_ff @(posedge clk) begin
      if (win) begin
         r0 <= RW'(row - CW'(K-1));
         c0 <= RW'(col - CW'(K-1));
      end
      if (v0) begin
         for (int e = 0; e < N; e++)
            prod[e] <= mul(bus.window_in[e*8 +: 8], wgt[e*8 +: 8]);
         r1 <= r0;
         c1 <= c0;
      end
      if (v1) begin
         for (int i = 0; i < K; i++)
            rsum[i] <= rsum_c[i];
         r2 <= r1;
         c2 <= c1;
      end
   end

   // Row sums, final sum with bias, and ReLU clamp.
   always_comb begin
      for (int i = 0; i < K; i++) begin
         rsum_c[i] = '0;
         for (int j = 0; j < K; j++)
            rsum_c[i] = rsum_c[i] + SW'(prod[i*K+j]);
      end
      tot_c = DW'(bias);
      for (int i = 0; i < K; i++)
         tot_c = tot_c + DW'(rsum[i]);
      res_c = (RELU_EN != 0 && tot_c[DW-1]) ? '0 : tot_c;
   end
endmodule

// File: tb/tb_conv_window_mac.sv
// tb_conv_window_mac: scoreboard bench driving one ReLU and one
// plain instance with identical streams of directed frames.
module tb_conv_window_mac;
   localparam int K_ERR = 0;
   localparam int K_RST = 1;
   localparam int K_QE  = 2;
   localparam int K_FD  = 3;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         pix_valid;
   logic         cfg_load;
   logic [199:0] window_in;
   logic [199:0] weight_in;
   logic [15:0]  bias_in;

   typedef struct {
      int     data;
      int     row;
      int     col;
      longint cyc;
   } exp_t;

   typedef struct {
      int kind;
      int id;
      int val;
   } st_t;

   exp_t   q [2][$];
   st_t    sq[$];
   int     errors = 0;
   int     checks = 0;
   longint cyc = 0;
   int     fd_cnt [2] = '{0, 0};
   int     frames = 0;

   always #5 clk = ~clk;

   always @(posedge clk) cyc <= cyc + 1;

   conv_window_mac_if bus1 ();
   conv_window_mac_if bus0 ();

   assign bus1.pix_valid = pix_valid;
   assign bus1.window_in = window_in;
   assign bus1.cfg_load  = cfg_load;
   assign bus1.weight_in = weight_in;
   assign bus1.bias_in   = bias_in;
   assign bus0.pix_valid = pix_valid;
   assign bus0.window_in = window_in;
   assign bus0.cfg_load  = cfg_load;
   assign bus0.weight_in = weight_in;
   assign bus0.bias_in   = bias_in;

   conv_window_mac #(.RELU_EN(1)) dut1 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus1)
   );

   conv_window_mac #(.RELU_EN(0)) dut0 (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus0)
   );

   task automatic mon(
      input int          id,
      input logic        ov,
      input logic [23:0] d,
      input logic [4:0]  r,
      input logic [4:0]  c,
      input logic        fd
   );
      exp_t e;
      bit   ok;
      while (q[id].size() > 0 && q[id][0].cyc < cyc) begin
         e = q[id].pop_front();
         checks++;
         errors++;
         $display("FAIL missing_out dut%0d: none, need (%0d,%0d)=%0d at cyc %0d",
                  id, e.row, e.col, e.data, e.cyc);
      end
      if (ov === 1'b1) begin
         checks++;
         if (fd === 1'b1) fd_cnt[id]++;
         if (q[id].size() == 0) begin
            errors++;
            $display("FAIL unexpected_out dut%0d: (%0d,%0d)=%0d at cyc %0d, need none",
                     id, r, c, $signed(d), cyc);
         end else begin
            e  = q[id].pop_front();
            ok = int'($signed(d)) == e.data && r == e.row &&
                 c == e.col && cyc == e.cyc &&
                 fd === (e.row == 23 && e.col == 23);
            if (!ok) begin
               errors++;
               $display("FAIL out dut%0d: got (%0d,%0d)=%0d fd=%0b cyc %0d, need (%0d,%0d)=%0d cyc %0d",
                        id, r, c, $signed(d), fd, cyc,
                        e.row, e.col, e.data, e.cyc);
            end
         end
      end else if (fd === 1'b1) begin
         checks++;
         errors++;
         $display("FAIL fd_no_valid dut%0d: frame_done=1, need 0", id);
      end
   endtask

   // Output monitor and status checker.
   always @(negedge clk) begin
      st_t        s;
      logic [35:0] st;
      int         act;
      mon(1, bus1.out_valid, bus1.out_data, bus1.out_row,
          bus1.out_col, bus1.frame_done);
      mon(0, bus0.out_valid, bus0.out_data, bus0.out_row,
          bus0.out_col, bus0.frame_done);
      while (sq.size() > 0) begin
         s = sq.pop_front();
         checks++;
         case (s.kind)
            K_ERR: begin
               act = (s.id == 1) ? int'(bus1.err) : int'(bus0.err);
               if (act != s.val) begin
                  errors++;
                  $display("FAIL err dut%0d: got %0d, need %0d",
                           s.id, act, s.val);
               end
            end
            K_RST: begin
               st = (s.id == 1) ?
                  {bus1.out_valid, bus1.frame_done, bus1.err,
                   bus1.out_data, bus1.out_row, bus1.out_col} :
                  {bus0.out_valid, bus0.frame_done, bus0.err,
                   bus0.out_data, bus0.out_row, bus0.out_col};
               if (st !== '0) begin
                  errors++;
                  $display("FAIL reset_state dut%0d: got %h, need 0",
                           s.id, st);
               end
            end
            K_QE: begin
               act = q[0].size() + q[1].size();
               if (act != 0) begin
                  errors++;
                  $display("FAIL pending_outputs: got %0d, need 0", act);
               end
            end
            default: begin
               act = fd_cnt[s.id];
               if (act != s.val) begin
                  errors++;
                  $display("FAIL frame_done_count dut%0d: got %0d, need %0d",
                           s.id, act, s.val);
               end
            end
         endcase
      end
   end

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic post(input int kind, input int id, input int val);
      st_t s;
      s = '{kind, id, val};
      sq.push_back(s);
   endtask

   task automatic post2(input int kind, input int val);
      post(kind, 0, val);
      post(kind, 1, val);
   endtask

   task automatic idle(input int n);
      repeat (n) begin
         step();
         pix_valid = 1'b0;
      end
   endtask

   task automatic load(input logic [199:0] w, input logic [15:0] b);
      step();
      cfg_load  = 1'b1;
      weight_in = w;
      bias_in   = b;
      step();
      cfg_load  = 1'b0;
   endtask

   // Streams n pixels, then one tail cycle with pix_valid low
   // (optionally with reset). Expected results are queued for
   // every window whose output precedes any abort.
   task automatic run_frame(
      input int           n,
      input logic [199:0] win,
      input bit           ramp,
      input int           e1,
      input int           e0,
      input int           cfg_at,
      input bit           rst_tail
   );
      logic [7:0] pv;
      int         r, c, x1, x0;
      exp_t       e;
      for (int i = 0; i <= n; i++) begin
         step();
         pix_valid = (i < n);
         pv        = 8'((i % 4) + 1);
         window_in = ramp ? {25{pv}} : win;
         cfg_load  = (i == cfg_at);
         if (i == cfg_at) begin
            weight_in = {25{8'd2}};
            bias_in   = 16'd50;
         end
         if (i == n && rst_tail) rst_n = 1'b0;
         r = i / 28;
         c = i % 28;
         if (i < n && r >= 4 && c >= 4 && (n == 784 || i + 4 <= n)) begin
            x1 = ramp ? 25 * (((i + 1) % 4) + 1) : e1;
            x0 = ramp ? 25 * (((i + 1) % 4) + 1) : e0;
            e  = '{x1, r - 4, c - 4, cyc + 4};
            q[1].push_back(e);
            e  = '{x0, r - 4, c - 4, cyc + 4};
            q[0].push_back(e);
         end
      end
      cfg_load = 1'b0;
      if (n == 784) frames++;
      if (rst_tail) begin
         step();
         rst_n = 1'b1;
         post2(K_RST, 0);
      end
   endtask

   initial begin
      logic [199:0] ones, wk, oh;
      rst_n     = 1'b0;
      pix_valid = 1'b0;
      cfg_load  = 1'b0;
      window_in = '0;
      weight_in = '0;
      bias_in   = '0;
      ones      = {25{8'd1}};
      wk        = '0;
      for (int k = 0; k < 25; k++) wk[k*8 +: 8] = 8'(k - 12);
      oh          = '0;
      oh[0 +: 8]  = 8'd7;
      oh[40 +: 8] = 8'd10;
      oh[192 +: 8] = 8'd200;

      repeat (3) step();
      rst_n = 1'b1;
      post2(K_RST, 0);

      load(ones, 16'd0);
      run_frame(784, '0, 1'b1, 0, 0, -1, 1'b0);
      idle(5);

      run_frame(784, ones, 1'b0, 25, 25, 400, 1'b0);
      idle(5);
      post2(K_ERR, 0);
      post2(K_FD, frames);

      load(ones, -16'sd100);
      run_frame(784, ones, 1'b0, 0, -75, -1, 1'b0);
      idle(5);

      load({25{8'h80}}, 16'h8000);
      run_frame(784, {25{8'hFF}}, 1'b0, 0, -848768, -1, 1'b0);
      idle(5);

      load(wk, -16'sd400);
      run_frame(784, oh, 1'b0, 1846, 1846, -1, 1'b0);
      idle(5);

      load(ones, 16'd0);
      run_frame(300, ones, 1'b0, 25, 25, -1, 1'b0);
      idle(2);
      post2(K_ERR, 1);
      idle(10);
      post(K_QE, 0, 0);
      load(ones, 16'd0);
      post2(K_ERR, 0);

      run_frame(784, ones, 1'b0, 25, 25, -1, 1'b0);
      step();
      pix_valid = 1'b1;
      step();
      pix_valid = 1'b0;
      idle(5);
      post2(K_ERR, 1);
      post(K_QE, 0, 0);
      load(ones, 16'd0);
      post2(K_ERR, 0);

      run_frame(784, ones, 1'b0, 25, 25, -1, 1'b0);
      idle(3);
      run_frame(784, ones, 1'b0, 25, 25, -1, 1'b0);
      idle(5);
      post2(K_FD, frames);
      post2(K_ERR, 0);

      run_frame(500, ones, 1'b0, 25, 25, -1, 1'b1);
      idle(10);
      post(K_QE, 0, 0);
      idle(2);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/conv_window_mac.md
CONV_WINDOW_MAC -- requirements
Module: conv_window_mac

Interface
REQ-001 SHALL have parameter IMG_W, default 28, meaning image width and height in pixels.
REQ-002 SHALL have parameter K, default 5, meaning kernel edge; the window is K*K 8-bit pixels.
REQ-003 SHALL have parameter RELU_EN, default 1, meaning clamp negative results to 0 when 1.
REQ-004 SHALL have port clk, input, 1, meaning single clock; all logic on rising edge.
REQ-005 SHALL have port rst_n, input, 1, meaning reset, synchronous and active-low.
REQ-006 SHALL have port pix_valid, input, 1, meaning a pixel enters the upstream line buffer this cycle.
REQ-007 SHALL have port window_in, input, 200, meaning 25 unsigned 8-bit pixels from the line buffer; element (i,j) is at bits [(5i+j)*8+7 : (5i+j)*8]; (0,0) is the newest pixel.
REQ-008 SHALL have port cfg_load, input, 1, meaning load weights and bias (accepted only in IDLE).
REQ-009 SHALL have port weight_in, input, 200, meaning 25 signed 8-bit weights in the same element order as window_in.
REQ-010 SHALL have port bias_in, input, 16, meaning signed bias.
REQ-011 SHALL have port out_valid, output, 1, meaning out_data/out_row/out_col are valid.
REQ-012 SHALL have port out_data, output, 24, meaning signed convolution result.
REQ-013 SHALL have port out_row, output, 5, meaning output row 0..23.
REQ-014 SHALL have port out_col, output, 5, meaning output column 0..23.
REQ-015 SHALL have port frame_done, output, 1, meaning one-cycle pulse on the final output of a frame.
REQ-016 SHALL have port err, output, 1, meaning sticky stream-protocol error.

Function
REQ-017 SHALL track the input pixel position with col counter 0..27 and row counter 0..27; col wraps to 0 and row increments on each accepted pixel at col 27.
REQ-018 SHALL implement FSM IDLE/RUN/DRAIN: IDLE->RUN on pix_valid (pixel counted as row 0, col 0); RUN->DRAIN on the pixel at row 27, col 27; DRAIN->IDLE after 4 cycles.
REQ-019 SHALL require pix_valid high for all 784 consecutive cycles of a frame in RUN; pix_valid low in RUN sets err, clears the counters, flushes the pipeline valids, and returns to IDLE.
REQ-020 SHALL set err on pix_valid high in DRAIN, ignore that pixel, and continue DRAIN.
REQ-021 SHALL mark the window complete when a pixel is accepted at cycle t with row>=4 and col>=4, and SHALL sample window_in at cycle t+1.
REQ-022 SHALL use pipeline stage 1 (t+2) to register 25 products, each unsigned 8-bit pixel times signed 8-bit weight giving 16-bit signed.
REQ-023 SHALL use pipeline stage 2 (t+3) to register 5 row sums of 5 products each, 19-bit signed.
REQ-024 SHALL use pipeline stage 3 (t+4) to register the sum of the 5 row sums plus sign-extended bias, sign-extended to 24 bits; apply ReLU when RELU_EN=1; overflow is impossible.
REQ-025 SHALL assert out_valid at t+4 with out_row=row-4 and out_col=col-4 of the triggering pixel, giving exactly 576 outputs per frame.
REQ-026 SHALL assert frame_done in the same cycle as the out_valid for out_row=23, out_col=23.
REQ-027 SHALL, on cfg_load in IDLE, register weight_in and bias_in into the coefficient registers and clear err; SHALL ignore cfg_load in RUN and DRAIN.
REQ-028 SHALL hold out_data, out_row and out_col at their last values when out_valid is low.

Reset
REQ-029 SHALL, when rst_n is low at a clock edge, go to IDLE and clear counters, pipeline valids, out_valid, frame_done, err, out_data, out_row, out_col, weights and bias to 0, including mid-frame.
REQ-030 SHALL produce no out_valid for any window in flight when reset is applied.

Verification
REQ-031 SHALL be verified with weights all 1, bias 0, every pixel 1, one 784-cycle frame -> 576 outputs of 25; the first output is at 4 cycles after pixel index 116 with row/col 0/0.
REQ-032 SHALL be verified with RELU_EN=1, weights all 1, bias -100, pixels 1 -> every out_data 0; RELU_EN=0 -> every out_data -75.
REQ-033 SHALL be verified with RELU_EN=0, pixels 255, weights -128, bias -32768 -> out_data -848768, i.e. 24'hF30C80.
REQ-034 SHALL be verified with pix_valid dropped at pixel index 300 -> err=1, no further out_valid, FSM in IDLE; a following full frame yields 576 correct outputs.
REQ-035 SHALL be verified with cfg_load of new weights mid-RUN -> ignored, frame results use the old weights; rst_n low at pixel 500 -> all outputs 0 on the next cycle and no pending out_valid.
REQ-036 SHALL be verified with two back-to-back frames, the second starting on the cycle after DRAIN ends -> 1152 outputs and two frame_done pulses, each coincident with output (23,23).
